// File: rtl/led_pkg.sv
// Shared constants and helpers for the switch-to-LED decoder/chaser.
package led_pkg;

  // Internal one-hot vector is active-high; output polarity is applied at the led register.
  localparam logic LED_ON  = 1'b1;
  localparam logic LED_OFF = 1'b0;

  localparam logic MODE_DECODE = 1'b0;
  localparam logic MODE_CHASE  = 1'b1;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic {
    ST_DECODE = 1'b0,
    ST_CHASE  = 1'b1
  } chase_state_e;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/led_decoder_seq_sw_debounce.sv
// Two-flop synchroniser plus whole-bus debounce for the select switches.
module sw_debounce
  import led_pkg::*;
#(
  parameter int WIDTH      = 3,
  parameter int DEB_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sel_q
);

  localparam int CW_RAW = clog2(DEB_CYCLES + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] CNT_DONE = CW'(DEB_CYCLES);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sw_s_q;
  logic [WIDTH-1:0] sw_prev_q;
  logic [WIDTH-1:0] sel_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [CW-1:0]    cnt_inc;

  // Count consecutive cycles the synchronised bus holds one value different from sel_q;
  // a change of that value restarts the count at 1.
  always_comb begin
    sel_d   = sel_q;
    cnt_d   = '0;
    cnt_inc = CW'(1);
    if (sw_s_q != sel_q) begin
      if (cnt_q != '0 && sw_s_q == sw_prev_q) begin
        cnt_inc = cnt_q + CW'(1);
      end
      if (cnt_inc == CNT_DONE) begin
        sel_d = sw_s_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  // Synchroniser, previous-sample register, counter and committed select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sw_s_q    <= '0;
      sw_prev_q <= '0;
      cnt_q     <= '0;
      sel_q     <= '0;
    end else begin
      sync1_q   <= sw;
      sw_s_q    <= sync1_q;
      sw_prev_q <= sw_s_q;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
    end
  end

endmodule

// File: rtl/led_decoder_seq.sv
// Switch-to-LED decoder with debounced select, output enable and a chase mode.
//
// state     | meaning
// ST_DECODE | led shows the decode of sel_q; entering chase reloads pos from sel_q
// ST_CHASE  | pos steps every CHASE_DIV cycles while en=1; led shows pos
module led_decoder_seq
  import led_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int N_LED      = 8,
  parameter int ACTIVE_LOW = 1,
  parameter int DEB_CYCLES = 50000,
  parameter int CHASE_DIV  = 5000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] sw,
  input  logic             mode,
  input  logic             dir,
  input  logic             en,
  output logic [N_LED-1:0] led,
  output logic [SEL_W-1:0] sel_q
);

  localparam int PW = (clog2(N_LED) < 1) ? 1 : clog2(N_LED);
  localparam int TW = (clog2(CHASE_DIV) < 1) ? 1 : clog2(CHASE_DIV);
  localparam logic [PW-1:0]    POS_LAST  = PW'(N_LED - 1);
  localparam logic [TW-1:0]    TICK_LAST = TW'(CHASE_DIV - 1);
  localparam logic [N_LED-1:0] LED_IDLE  = (ACTIVE_LOW != 0) ? {N_LED{1'b1}} : {N_LED{1'b0}};

  logic             mode_m_q, mode_s_q;
  logic             dir_m_q, dir_s_q;
  chase_state_e     st_q, st_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic [N_LED-1:0] led_q, led_d;
  logic [N_LED-1:0] vec;
  logic             sel_in_range;
  logic             show_chase;

  sw_debounce #(
    .WIDTH      (SEL_W),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_sw_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw),
    .sel_q (sel_q)
  );

  assign sel_in_range = (32'(sel_q) < N_LED);
  // On the entry edge pos is not yet loaded, so the decode of sel_q is shown for that cycle.
  assign show_chase   = (mode_s_q == MODE_CHASE) && (st_q == ST_CHASE);

  // Mode tracking, chase position reload on entry and tick/step while enabled.
  always_comb begin
    st_d   = (mode_s_q == MODE_CHASE) ? ST_CHASE : ST_DECODE;
    pos_d  = pos_q;
    tick_d = tick_q;
    if (mode_s_q == MODE_CHASE && st_q == ST_DECODE) begin
      pos_d  = sel_in_range ? sel_q[PW-1:0] : '0;
      tick_d = '0;
    end else if (mode_s_q == MODE_CHASE && en) begin
      if (tick_q == TICK_LAST) begin
        tick_d = '0;
        if (dir_s_q == DIR_DOWN) begin
          pos_d = (pos_q == '0) ? POS_LAST : pos_q - PW'(1);
        end else begin
          pos_d = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
        end
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end
  end

  // One-hot display vector, polarity applied on the way into the output register.
  always_comb begin
    vec = {N_LED{LED_OFF}};
    if (en) begin
      for (int i = 0; i < N_LED; i++) begin
        if (show_chase ? (pos_q == PW'(i)) : (sel_q == SEL_W'(i))) begin
          vec[i] = LED_ON;
        end
      end
    end
    led_d = (ACTIVE_LOW != 0) ? ~vec : vec;
  end

  // Control synchronisers, chase state and registered LED drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_m_q <= 1'b0;
      mode_s_q <= 1'b0;
      dir_m_q  <= 1'b0;
      dir_s_q  <= 1'b0;
      st_q     <= ST_DECODE;
      pos_q    <= '0;
      tick_q   <= '0;
      led_q    <= LED_IDLE;
    end else begin
      mode_m_q <= mode;
      mode_s_q <= mode_m_q;
      dir_m_q  <= dir;
      dir_s_q  <= dir_m_q;
      st_q     <= st_d;
      pos_q    <= pos_d;
      tick_q   <= tick_d;
      led_q    <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_led_decoder_seq.sv
// Self-checking bench: an 8-LED and a 6-LED instance share the same stimulus.
module tb_led_decoder_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] sw;
  logic       mode;
  logic       dir;
  logic       en;
  logic [7:0] led8;
  logic [2:0] sel8;
  logic [5:0] led6;
  logic [2:0] sel6;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_led_q[$];
  logic [5:0] exp_led6_q[$];

  always #5 clk = ~clk;

  led_decoder_seq #(
    .SEL_W(3), .N_LED(8), .ACTIVE_LOW(1), .DEB_CYCLES(4), .CHASE_DIV(3)
  ) dut8 (
    .clk(clk), .rst_n(rst_n), .sw(sw), .mode(mode), .dir(dir), .en(en),
    .led(led8), .sel_q(sel8)
  );

  led_decoder_seq #(
    .SEL_W(3), .N_LED(6), .ACTIVE_LOW(1), .DEB_CYCLES(4), .CHASE_DIV(3)
  ) dut6 (
    .clk(clk), .rst_n(rst_n), .sw(sw), .mode(mode), .dir(dir), .en(en),
    .led(led6), .sel_q(sel6)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sel(input logic [2:0] v, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (sel8 !== v && n < 40);
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0; sw = 3'd0; mode = 1'b0; dir = 1'b0; en = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    n = 0;
    while (led8 !== 8'hFE && n < 2) begin step(); n++; end
    checks++;
    if (led8 !== 8'hFE) begin
      errors++; $display("FAIL reset_release_led: got %h required FE within 2 edges", led8);
    end
    repeat (2) step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (led8 !== 8'hFF) begin errors++; $display("FAIL reset_async_led8: got %h required FF", led8); end
    checks++;
    if (led6 !== 6'h3F) begin errors++; $display("FAIL reset_async_led6: got %h required 3F", led6); end
    checks++;
    if (sel8 !== 3'd0) begin errors++; $display("FAIL reset_async_sel: got %0d required 0", sel8); end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (led8 !== 8'hFE) begin errors++; $display("FAIL reset_rerelease_led: got %h required FE", led8); end
  endtask

  task automatic test_decode();
    int vals[8] = '{5, 1, 2, 3, 4, 6, 7, 0};
    int n;
    logic [2:0] v;
    logic [7:0] e8;
    logic [5:0] e6;
    for (int k = 0; k < 8; k++) begin
      v = 3'(vals[k]);
      exp_led_q.push_back(~(8'd1 << v));
      exp_led6_q.push_back((v < 3'd6) ? ~(6'd1 << v) : 6'h3F);
      sw = v;
      wait_sel(v, n);
      checks++;
      if (n != 6 || sel8 !== v) begin
        errors++;
        $display("FAIL decode_latency sw=%0d: sel_q=%0d after %0d edges, required %0d after 6", v, sel8, n, v);
      end
      step();
      e8 = exp_led_q.pop_front();
      e6 = exp_led6_q.pop_front();
      checks++;
      if (led8 !== e8) begin errors++; $display("FAIL decode_led8 sw=%0d: got %h required %h", v, led8, e8); end
      checks++;
      if (led6 !== e6) begin errors++; $display("FAIL decode_led6 sw=%0d: got %h required %h", v, led6, e6); end
      checks++;
      if (sel6 !== v) begin errors++; $display("FAIL decode_sel6 sw=%0d: got %0d required %0d", v, sel6, v); end
    end
  endtask

  task automatic test_glitch();
    int n;
    logic [7:0] e8;
    sw = 3'd3;
    repeat (3) step();
    sw = 3'd0;
    repeat (12) step();
    checks++;
    if (sel8 !== 3'd0) begin errors++; $display("FAIL glitch_sel: got %0d required 0", sel8); end
    checks++;
    if (led8 !== 8'hFE) begin errors++; $display("FAIL glitch_led: got %h required FE", led8); end
    sw = 3'd3;
    repeat (3) step();
    exp_led_q.push_back(8'hDF);
    sw = 3'd5;
    wait_sel(3'd5, n);
    checks++;
    if (n != 6 || sel8 !== 3'd5) begin
      errors++; $display("FAIL glitch_restart: sel_q=%0d after %0d edges, required 5 after 6", sel8, n);
    end
    step();
    e8 = exp_led_q.pop_front();
    checks++;
    if (led8 !== e8) begin errors++; $display("FAIL glitch_restart_led: got %h required %h", led8, e8); end
  endtask

  task automatic observe_chase(input int n_vals);
    logic [7:0] last, e;
    int hold, seen, cyc;
    e = exp_led_q.pop_front();
    checks++;
    if (led8 !== e) begin errors++; $display("FAIL chase_first: got %h required %h", led8, e); end
    last = led8; seen = 1; hold = 0; cyc = 0;
    while (seen < n_vals && cyc < 60) begin
      step(); cyc++; hold++;
      if (led8 !== last) begin
        if (seen == 1) begin
          checks++;
          if (cyc != 7) begin errors++; $display("FAIL chase_entry_latency: first step after %0d edges, required 7", cyc); end
        end else begin
          checks++;
          if (hold != 3) begin errors++; $display("FAIL chase_hold: %h held %0d cycles, required 3", last, hold); end
        end
        e = exp_led_q.pop_front();
        checks++;
        if (led8 !== e) begin errors++; $display("FAIL chase_step: got %h required %h", led8, e); end
        last = led8; hold = 0; seen++;
      end
    end
    checks++;
    if (seen != n_vals) begin errors++; $display("FAIL chase_timeout: saw %0d values, required %0d", seen, n_vals); end
  endtask

  task automatic test_chase();
    int n;
    sw = 3'd6;
    wait_sel(3'd6, n);
    step();
    checks++;
    if (led8 !== 8'hBF) begin errors++; $display("FAIL chase_setup: got %h required BF", led8); end
    dir = 1'b0;
    exp_led_q.push_back(8'hBF);
    exp_led_q.push_back(8'h7F);
    exp_led_q.push_back(8'hFE);
    exp_led_q.push_back(8'hFD);
    mode = 1'b1;
    observe_chase(4);
    mode = 1'b0;
    repeat (3) step();
    checks++;
    if (led8 !== 8'hBF) begin errors++; $display("FAIL chase_exit: got %h required BF", led8); end
    dir = 1'b1;
    sw = 3'd0;
    wait_sel(3'd0, n);
    step();
    checks++;
    if (led8 !== 8'hFE) begin errors++; $display("FAIL chase_reload_setup: got %h required FE", led8); end
    exp_led_q.push_back(8'hFE);
    exp_led_q.push_back(8'h7F);
    exp_led_q.push_back(8'hBF);
    mode = 1'b1;
    observe_chase(3);
  endtask

  task automatic test_enable();
    logic [7:0] last, l_saved, h, nh;
    int n;
    last = led8; n = 0;
    while (led8 === last && n < 10) begin step(); n++; end
    l_saved = led8;
    en = 1'b0;
    step();
    checks++;
    if (led8 !== 8'hFF) begin errors++; $display("FAIL enable_off_led8: got %h required FF", led8); end
    checks++;
    if (led6 !== 6'h3F) begin errors++; $display("FAIL enable_off_led6: got %h required 3F", led6); end
    repeat (8) step();
    checks++;
    if (led8 !== 8'hFF) begin errors++; $display("FAIL enable_held_off: got %h required FF", led8); end
    en = 1'b1;
    step();
    checks++;
    if (led8 !== l_saved) begin errors++; $display("FAIL enable_resume: got %h required %h", led8, l_saved); end
    h = ~l_saved;
    nh = {h[0], h[7:1]};
    n = 0;
    while (led8 === l_saved && n < 10) begin step(); n++; end
    checks++;
    if (led8 !== ~nh) begin errors++; $display("FAIL enable_next_step: got %h required %h", led8, ~nh); end
  endtask

  task automatic test_reset_mid();
    int n;
    mode = 1'b0;
    sw = 3'd2;
    wait_sel(3'd2, n);
    mode = 1'b1;
    repeat (8) step();
    sw = 3'd5;
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (led8 !== 8'hFF) begin errors++; $display("FAIL midreset_led: got %h required FF", led8); end
    checks++;
    if (sel8 !== 3'd0) begin errors++; $display("FAIL midreset_sel: got %0d required 0", sel8); end
    mode = 1'b0;
    step();
    rst_n = 1'b1;
    wait_sel(3'd5, n);
    checks++;
    if (n != 6 || sel8 !== 3'd5) begin
      errors++; $display("FAIL midreset_debounce: sel_q=%0d after %0d edges, required 5 after 6", sel8, n);
    end
    step();
    checks++;
    if (led8 !== 8'hDF) begin errors++; $display("FAIL midreset_led_after: got %h required DF", led8); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_glitch();
    test_chase();
    test_enable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/led_decoder_seq.md
Name: led_decoder_seq

Overview:
Parametrised successor to the board's switch-to-LED 3-8 decoder. It adds a two-flop synchroniser and debouncer on the switch bus, registered one-hot outputs with selectable polarity, and a chase mode in which a lit position steps around the LED bank at a divided rate. The block sits between the board switch pins and the LED bank, on the single system clock.

Parameters:
SEL_W, 3, width of switch select bus.
N_LED, 8, number of LEDs; legal range 2..2**SEL_W.
ACTIVE_LOW, 1, 1 means a lit LED drives 0 and an unlit LED drives 1.
DEB_CYCLES, 50000, consecutive stable cycles required to commit a switch change; minimum 1.
CHASE_DIV, 5000000, clock cycles per chase step; minimum 1.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
sw  in  SEL_W  raw select switches (asynchronous to clk).
mode  in  1  0 = decode mode, 1 = chase mode (synchronised internally).
dir  in  1  chase direction: 0 = up (index +1), 1 = down (index -1); synchronised internally.
en  in  1  output enable, synchronous; 0 turns all LEDs off.
led  out  N_LED  LED drive, registered.
sel_q  out  SEL_W  committed (debounced) select value, registered.

Behaviour:
- Reset (rst_n=0, asynchronous): led = all-unlit (all 1 if ACTIVE_LOW, else all 0); sel_q = 0; synchronisers, debounce counter, chase position and tick counter all 0. Outputs release on the first clk edge after rst_n rises. Reset mid-debounce or mid-chase discards all progress.
- Synchroniser: sw, mode and dir each pass through 2 flops. sw_s denotes the synchronised sw.
- Debounce, treating the whole bus as one value:
  - If sw_s == sel_q, the counter is cleared to 0.
  - Otherwise the counter increments each cycle.
  - If sw_s changes value while the counter is running, the counter restarts at 1.
  - When the counter reaches DEB_CYCLES, sel_q <= sw_s on that edge and the counter clears.
  - A glitch shorter than DEB_CYCLES never reaches sel_q.
- Decode mode (mode_s=0, en=1):
  - led is lit only at bit index sel_q.
  - If sel_q >= N_LED, all LEDs are unlit.
  - led updates one edge after sel_q. Total latency from a clean sw change to led is 2 + DEB_CYCLES + 1 edges.
- Chase mode (mode_s=1, en=1):
  - The tick counter counts 0..CHASE_DIV-1. On the terminal count it wraps to 0 and pos steps.
  - dir_s=0: pos = (pos == N_LED-1) ? 0 : pos+1.
  - dir_s=1: pos = (pos == 0) ? N_LED-1 : pos-1.
  - led is lit only at index pos, registered one edge after pos.
- Mode entry into chase (mode_s 0→1):
  - On that edge, pos <= sel_q (or 0 if sel_q >= N_LED) and the tick counter clears.
  - The first step occurs CHASE_DIV edges later.
- Mode exit: led returns to the decode of sel_q on the next edge. pos is retained but reloaded on the next entry.
- A dir_s change takes effect at the next step and never causes an immediate step.
- en=0: led = all-unlit on the next edge; pos and the tick counter are frozen; debounce continues and sel_q still updates. When en returns to 1, the display resumes from the frozen pos.
- Width rules:
  - pos is clog2(N_LED) bits, minimum 1.
  - The tick counter is clog2(CHASE_DIV) bits, minimum 1.
  - The debounce counter is clog2(DEB_CYCLES+1) bits.
  - No arithmetic overflow is permitted; wrap is explicit as specified above.
- Polarity: the internal one-hot vector is active-high and is inverted at the output register when ACTIVE_LOW=1.

Decomposition:
- Shared package led_pkg: polarity constants LED_ON/LED_OFF, mode encodings MODE_DECODE=0 and MODE_CHASE=1, DIR_UP=0 and DIR_DOWN=1, and a clog2 helper function.
- One sub-module, sw_debounce, parametrised by WIDTH and DEB_CYCLES, containing the 2-flop sync and bus debounce and outputting sel_q. The mode/dir synchronisers stay in the top module.

Test Plan:
1. Reset behaviour (DEB_CYCLES=4, CHASE_DIV=3, defaults otherwise): assert rst_n=0 asynchronously mid-cycle → led=8'hFF immediately, sel_q=0. After release with sw=0 and en=1 → led=8'hFE within 2 edges.
2. Clean decode: sw 0→5 held steady → sel_q=5 exactly 2+4 edges after the change, led=8'hDF one edge later. Repeat for all 8 values and check active-low one-hot.
3. Glitch rejection: sw=3 for 3 cycles then back to 0 → sel_q stays 0 and led stays 8'hFE. A toggle restarting mid-count resets the counter.
4. Chase wrap: sel_q=6, mode 0→1, dir=0 → led sequence 8'hBF, 8'h7F, 8'hFE, 8'hFD, each held 3 cycles. With dir=1 starting from pos 0 → next is 8'h7F.
5. Enable and range: N_LED=6, SEL_W=3, sw=7 → led=6'h3F (all off). en=0 during chase → led all off and pos frozen; en=1 → the same pos reappears.
6. Reset mid-operation: rst_n pulsed during chase and during a pending debounce → all state returns to 0; the pending sw change needs a full DEB_CYCLES again.
